// File: rtl/pos_seq_pkg.sv
// Shared definitions for the waypoint sequencer: state encoding, table
// geometry defaults and the position sample width.
package pos_seq_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   localparam int POS_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_SETTLE,
      ST_DWELL
   } seq_state_t;

endpackage

// File: rtl/pos_target_seq_settle.sv
// Settle detector: rising-edge sample strobe, absolute position error,
// window compare and consecutive in-window counter.
module pos_settle_det
   import pos_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sample,
   input  logic [POS_W-1:0] i_posAdc,
   input  logic [POS_W-1:0] i_posTarget,
   input  logic [POS_W-1:0] i_tolerance,
   input  logic [7:0]       i_settleSamples,
   input  logic             i_clear,
   output logic             o_settled
);

   logic             r_sampleDly;
   logic [7:0]       r_settleCnt;
   logic             w_edge;
   logic [POS_W:0]   w_diff;
   logic [POS_W:0]   w_absMag;
   logic [POS_W-1:0] w_absErr;
   logic             w_inWindow;
   logic [7:0]       w_settleTarget;

   assign w_edge = i_sample & ~r_sampleDly;
   assign w_diff = {1'b0, i_posAdc} - {1'b0, i_posTarget};

   // The 17-bit magnitude cannot exceed 16 bits for unsigned inputs, but the
   // clamp keeps the compare safe should the operand widths ever change.
   always_comb begin
      w_absMag = w_diff;
      if (w_diff[POS_W]) begin
         w_absMag = ~w_diff + (POS_W+1)'(1);
      end
      w_absErr = w_absMag[POS_W] ? '1 : w_absMag[POS_W-1:0];
   end

   assign w_inWindow     = (w_absErr <= i_tolerance);
   assign w_settleTarget = (i_settleSamples == 8'd0) ? 8'd1 : i_settleSamples;
   assign o_settled      = (r_settleCnt >= w_settleTarget);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sampleDly <= 1'b0;
         r_settleCnt <= 8'd0;
      end else begin
         r_sampleDly <= i_sample;
         if (i_clear) begin
            r_settleCnt <= 8'd0;
         end else if (w_edge) begin
            if (!w_inWindow) begin
               r_settleCnt <= 8'd0;
            end else if (!o_settled) begin
               r_settleCnt <= r_settleCnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/pos_target_seq.sv
// Waypoint sequencer: walks a table of position targets, issuing each to the
// position loop and waiting for it to settle and dwell before advancing.
module pos_target_seq
   import pos_seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
)(
   input  logic             clk_pid,
   input  logic             sys_rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [POS_W-1:0] wr_data,
   input  logic [AW:0]      num_points,
   input  logic             loop_en,
   input  logic             start,
   input  logic             abort,
   input  logic [POS_W-1:0] tolerance,
   input  logic [7:0]       settle_samples,
   input  logic [15:0]      dwell_cycles,
   input  logic [23:0]      timeout_cycles,
   input  logic             pos_adc_data_valid,
   input  logic [POS_W-1:0] pos_adc,
   output logic [POS_W-1:0] pos_target,
   output logic             spi_new_target_valid,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [AW-1:0]    cur_index
);

   localparam logic [AW:0] MAX_POINTS = (AW+1)'(DEPTH);

   seq_state_t       r_state;
   logic [POS_W-1:0] r_table [DEPTH];
   logic [AW-1:0]    r_index;
   logic [23:0]      r_timeoutCnt;
   logic [15:0]      r_dwellCnt;
   logic [POS_W-1:0] r_posTarget;
   logic             r_newValid;
   logic             r_busy;
   logic             r_done;
   logic             r_timeoutErr;

   logic             w_settled;
   logic             w_clear;
   logic             w_startOk;
   logic [AW:0]      w_lastIdx;
   logic             w_isLast;

   assign w_startOk = start && (num_points != '0) && (num_points <= MAX_POINTS);
   assign w_lastIdx = (num_points == '0) ? '0 : num_points - (AW+1)'(1);
   assign w_isLast  = ({1'b0, r_index} >= w_lastIdx);
   assign w_clear   = (r_state != ST_SETTLE);

   pos_settle_det u_settle (
      .i_clk           (clk_pid),
      .i_rst           (sys_rst),
      .i_sample        (pos_adc_data_valid),
      .i_posAdc        (pos_adc),
      .i_posTarget     (r_posTarget),
      .i_tolerance     (tolerance),
      .i_settleSamples (settle_samples),
      .i_clear         (w_clear),
      .o_settled       (w_settled)
   );

   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_table[i] <= '0;
         end
      end else if (wr_en && ({1'b0, wr_addr} < MAX_POINTS)) begin
         r_table[wr_addr] <= wr_data;
      end
   end

   // Abort overrides every transition and suppresses any pending pulse.
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= ST_IDLE;
         r_index      <= '0;
         r_timeoutCnt <= '0;
         r_dwellCnt   <= '0;
         r_posTarget  <= '0;
         r_newValid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_newValid <= 1'b0;
         r_done     <= 1'b0;
         if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_startOk) begin
                     r_state      <= ST_ISSUE;
                     r_index      <= '0;
                     r_timeoutErr <= 1'b0;
                     r_busy       <= 1'b1;
                  end
               end
               ST_ISSUE: begin
                  r_posTarget  <= r_table[r_index];
                  r_newValid   <= 1'b1;
                  r_timeoutCnt <= '0;
                  r_state      <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (w_settled) begin
                     r_state    <= ST_DWELL;
                     r_dwellCnt <= '0;
                  end else if ((timeout_cycles != '0) &&
                               (r_timeoutCnt + 24'd1 == timeout_cycles)) begin
                     r_timeoutErr <= 1'b1;
                     r_state      <= ST_IDLE;
                     r_busy       <= 1'b0;
                  end else begin
                     r_timeoutCnt <= r_timeoutCnt + 24'd1;
                  end
               end
               ST_DWELL: begin
                  if (r_dwellCnt >= dwell_cycles) begin
                     if (!w_isLast) begin
                        r_index <= r_index + AW'(1);
                        r_state <= ST_ISSUE;
                     end else if (loop_en) begin
                        r_index <= '0;
                        r_state <= ST_ISSUE;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_dwellCnt <= r_dwellCnt + 16'd1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pos_target           = r_posTarget;
   assign spi_new_target_valid = r_newValid;
   assign busy                 = r_busy;
   assign done                 = r_done;
   assign timeout_err          = r_timeoutErr;
   assign cur_index            = r_index;

endmodule

// File: tb/tb_pos_target_seq.sv
// Directed bench for pos_target_seq: waypoint issue, settle counting, dwell
// timing, timeout, looping, abort and reset behaviour.
module tb_pos_target_seq;

   localparam int AW = 4;

   logic          clk_pid = 1'b0;
   logic          sys_rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic [AW:0]   num_points;
   logic          loop_en;
   logic          start;
   logic          abort;
   logic [15:0]   tolerance;
   logic [7:0]    settle_samples;
   logic [15:0]   dwell_cycles;
   logic [23:0]   timeout_cycles;
   logic          pos_adc_data_valid;
   logic [15:0]   pos_adc;
   logic [15:0]   pos_target;
   logic          spi_new_target_valid;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [AW-1:0] cur_index;

   int vectorCount = 0;
   int missCount   = 0;
   int validCount  = 0;
   int doneCount   = 0;

   always #5 clk_pid = ~clk_pid;

   pos_target_seq #(.DEPTH(16), .AW(AW)) dut (
      .clk_pid              (clk_pid),
      .sys_rst              (sys_rst),
      .wr_en                (wr_en),
      .wr_addr              (wr_addr),
      .wr_data              (wr_data),
      .num_points           (num_points),
      .loop_en              (loop_en),
      .start                (start),
      .abort                (abort),
      .tolerance            (tolerance),
      .settle_samples       (settle_samples),
      .dwell_cycles         (dwell_cycles),
      .timeout_cycles       (timeout_cycles),
      .pos_adc_data_valid   (pos_adc_data_valid),
      .pos_adc              (pos_adc),
      .pos_target           (pos_target),
      .spi_new_target_valid (spi_new_target_valid),
      .busy                 (busy),
      .done                 (done),
      .timeout_err          (timeout_err),
      .cur_index            (cur_index)
   );

   // Pulse counters sampled on the falling edge, away from DUT updates.
   always @(negedge clk_pid) begin
      if (spi_new_target_valid) validCount++;
      if (done) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk_pid);
         #1;
      end
   endtask

   task automatic writeEntry(input logic [AW-1:0] addr, input logic [15:0] data);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulseAbort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   // One ADC sample: strobe high for a cycle, then low for a cycle.
   task automatic applyStimulus(input logic [15:0] value);
      pos_adc = value;
      pos_adc_data_valid = 1'b1;
      step();
      pos_adc_data_valid = 1'b0;
      step();
   endtask

   task automatic waitValid(input string tag, input int maxCycles, output int cycles);
      logic found;
      found = 1'b0;
      cycles = 0;
      while (!found && cycles < maxCycles) begin
         step();
         cycles++;
         if (spi_new_target_valid) found = 1'b1;
      end
      checkOutput(tag, 32'(found), 32'd1);
   endtask

   task automatic waitDone(input string tag, input int maxCycles);
      logic found;
      found = 1'b0;
      for (int i = 0; i < maxCycles && !found; i++) begin
         step();
         if (done) found = 1'b1;
      end
      checkOutput(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int vBase;
      int dBase;
      logic [15:0] expTarget;

      sys_rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      num_points = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
      tolerance = '0; settle_samples = '0; dwell_cycles = '0; timeout_cycles = '0;
      pos_adc_data_valid = 1'b0; pos_adc = '0;
      step(2);
      checkOutput("rst_target", 32'(pos_target), 32'd0);
      checkOutput("rst_valid",  32'(spi_new_target_valid), 32'd0);
      checkOutput("rst_busy",   32'(busy), 32'd0);
      checkOutput("rst_done",   32'(done), 32'd0);
      checkOutput("rst_tmo",    32'(timeout_err), 32'd0);
      checkOutput("rst_index",  32'(cur_index), 32'd0);
      sys_rst = 1'b0;
      step();

      // Two-point sequence with settle and dwell.
      writeEntry(4'd0, 16'd1000);
      writeEntry(4'd1, 16'd3000);
      num_points = 5'd2; tolerance = 16'd50; settle_samples = 8'd3;
      dwell_cycles = 16'd10; timeout_cycles = 24'd0;
      vBase = validCount; dBase = doneCount;
      pulseStart();
      checkOutput("seq_busy", 32'(busy), 32'd1);
      waitValid("seq_issue0", 4, cyc);
      checkOutput("seq_target0", 32'(pos_target), 32'd1000);
      checkOutput("seq_index0",  32'(cur_index), 32'd0);
      repeat (3) applyStimulus(16'd1000);
      waitValid("seq_issue1", 30, cyc);
      checkOutput("seq_dwell_latency", 32'(cyc), 32'd12);
      checkOutput("seq_target1", 32'(pos_target), 32'd3000);
      checkOutput("seq_index1",  32'(cur_index), 32'd1);
      repeat (3) applyStimulus(16'd3000);
      waitDone("seq_done", 30);
      checkOutput("seq_idle", 32'(busy), 32'd0);
      step(2);
      checkOutput("seq_valid_count", 32'(validCount - vBase), 32'd2);
      checkOutput("seq_done_count",  32'(doneCount - dBase), 32'd1);

      // Out-of-window sample in the middle restarts the settle count.
      num_points = 5'd1; dwell_cycles = 16'd0;
      dBase = doneCount;
      pulseStart();
      waitValid("reset_issue", 4, cyc);
      applyStimulus(16'd1000);
      applyStimulus(16'd1100);
      applyStimulus(16'd1000);
      applyStimulus(16'd1000);
      checkOutput("reset_still_busy", 32'(busy), 32'd1);
      checkOutput("reset_no_done", 32'(doneCount - dBase), 32'd0);
      applyStimulus(16'd1000);
      step();
      checkOutput("reset_fifth_done", 32'(done), 32'd1);
      checkOutput("reset_fifth_idle", 32'(busy), 32'd0);

      // Window edges: error equal to tolerance counts, one more does not.
      settle_samples = 8'd2;
      pulseStart();
      waitValid("win_issue", 4, cyc);
      applyStimulus(16'd1050);
      applyStimulus(16'd949);
      applyStimulus(16'd950);
      checkOutput("win_outside_busy", 32'(busy), 32'd1);
      applyStimulus(16'd1050);
      step();
      checkOutput("win_inside_done", 32'(done), 32'd1);

      // Settle timeout with no samples arriving.
      settle_samples = 8'd3; timeout_cycles = 24'd200; pos_adc = 16'd0;
      dBase = doneCount;
      pulseStart();
      waitValid("tmo_issue", 4, cyc);
      step(199);
      checkOutput("tmo_before", 32'(timeout_err), 32'd0);
      checkOutput("tmo_before_busy", 32'(busy), 32'd1);
      step();
      checkOutput("tmo_at_200", 32'(timeout_err), 32'd1);
      checkOutput("tmo_idle", 32'(busy), 32'd0);
      step(2);
      checkOutput("tmo_no_done", 32'(doneCount - dBase), 32'd0);
      pulseStart();
      checkOutput("tmo_cleared", 32'(timeout_err), 32'd0);
      checkOutput("tmo_restart_busy", 32'(busy), 32'd1);
      pulseAbort();
      checkOutput("tmo_abort_idle", 32'(busy), 32'd0);
      timeout_cycles = 24'd0;

      // Looping two-point sequence, aborted while dwelling.
      num_points = 5'd2; loop_en = 1'b1; settle_samples = 8'd1; dwell_cycles = 16'd2;
      pulseStart();
      for (int k = 0; k < 4; k++) begin
         expTarget = (k % 2 == 0) ? 16'd1000 : 16'd3000;
         waitValid($sformatf("loop_issue%0d", k), 20, cyc);
         checkOutput($sformatf("loop_index%0d", k), 32'(cur_index), 32'(k % 2));
         checkOutput($sformatf("loop_target%0d", k), 32'(pos_target), 32'(expTarget));
         applyStimulus(expTarget);
      end
      vBase = validCount; dBase = doneCount;
      pulseAbort();
      checkOutput("abort_idle", 32'(busy), 32'd0);
      checkOutput("abort_target", 32'(pos_target), 32'd3000);
      step(6);
      checkOutput("abort_no_valid", 32'(validCount - vBase), 32'd0);
      checkOutput("abort_no_done", 32'(doneCount - dBase), 32'd0);
      loop_en = 1'b0;

      // Ignored starts.
      vBase = validCount;
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      checkOutput("startabort_idle", 32'(busy), 32'd0);
      step(3);
      checkOutput("startabort_no_valid", 32'(validCount - vBase), 32'd0);
      num_points = 5'd0;
      pulseStart();
      checkOutput("np0_ignored", 32'(busy), 32'd0);
      num_points = 5'd17;
      pulseStart();
      checkOutput("np17_ignored", 32'(busy), 32'd0);

      // Reset in the middle of settling, then the cleared table.
      num_points = 5'd1;
      writeEntry(4'd0, 16'd1234);
      pulseStart();
      waitValid("rstmid_issue", 4, cyc);
      checkOutput("rstmid_target_pre", 32'(pos_target), 32'd1234);
      sys_rst = 1'b1;
      #1;
      checkOutput("rstmid_valid", 32'(spi_new_target_valid), 32'd0);
      checkOutput("rstmid_target", 32'(pos_target), 32'd0);
      checkOutput("rstmid_busy", 32'(busy), 32'd0);
      step();
      sys_rst = 1'b0;
      step();
      pulseStart();
      waitValid("rstmid_reissue", 4, cyc);
      checkOutput("rstmid_table_cleared", 32'(pos_target), 32'd0);
      pulseAbort();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
